// File: rtl/hall_call_dispatcher_if.sv
// Hall-call dispatcher bus: call inputs, car status, floor requests, call status.
interface hall_call_dispatcher_if #(
    parameter int N_FLOORS = 12,
    parameter int N_LIFTS  = 4
);
    localparam int FW = $clog2(N_FLOORS);

    logic [N_FLOORS-1:0]         hall_up_req;
    logic [N_FLOORS-1:0]         hall_dn_req;
    logic [N_LIFTS*FW-1:0]       lift_floor;
    logic [N_LIFTS-1:0]          lift_motion;
    logic [N_LIFTS-1:0]          lift_door_open;
    logic [N_LIFTS-1:0]          lift_avail;
    logic [N_LIFTS*N_FLOORS-1:0] assign_flr_rqst;
    logic [N_FLOORS-1:0]         hall_up_pending;
    logic [N_FLOORS-1:0]         hall_dn_pending;
    logic                        dispatch_busy;

    modport master (
        output hall_up_req, hall_dn_req, lift_floor,
        output lift_motion, lift_door_open, lift_avail,
        input  assign_flr_rqst, hall_up_pending,
        input  hall_dn_pending, dispatch_busy
    );

    modport slave (
        input  hall_up_req, hall_dn_req, lift_floor,
        input  lift_motion, lift_door_open, lift_avail,
        output assign_flr_rqst, hall_up_pending,
        output hall_dn_pending, dispatch_busy
    );
endinterface

// File: rtl/hall_call_dispatcher.sv
// Hall-call table plus nearest-car dispatcher (IDLE/SCAN/EVAL/ISSUE).
// Optional DISPATCH_TIMEOUT_EN adds per-call age counters that force redispatch.
module hall_call_dispatcher #(
    parameter int N_FLOORS       = 12,
    parameter int N_LIFTS        = 4,
    parameter int TIMEOUT_CYCLES = 200
) (
    input logic                   clk,
    input logic                   reset,
    hall_call_dispatcher_if.slave bus
);
    localparam int FW = $clog2(N_FLOORS);
    localparam int LW = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1;
    localparam int NE = 2 * N_FLOORS;
    localparam int EW = $clog2(NE);
    localparam int CW = FW + 2;

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, ISSUE} state_e;

    logic [NE-1:0] pending_q, pending_d;
    logic [NE-1:0] assigned_q, assigned_d;
    logic [LW-1:0] owner_q [NE];
    logic [LW-1:0] owner_d [NE];
    logic [NE-1:0] req, cand, clr, aged;

    state_e                      state_q;
    logic [EW-1:0]               ptr_q, entry_q, ptr_next;
    logic [LW-1:0]               eval_q, winner_q;
    logic                        found_q, busy_q;
    logic [CW-1:0]               best_q;
    logic [N_LIFTS*N_FLOORS-1:0] pulse_q, issue_vec;

    logic          scan_hit, better, issue_fire;
    logic [EW-1:0] scan_sel;
    logic [FW-1:0] cf, lf;
    logic [CW-1:0] cost;

    function automatic logic [FW-1:0] floor_of(input logic [EW-1:0] e);
        if (int'(e) >= N_FLOORS) return FW'(int'(e) - N_FLOORS);
        return FW'(e);
    endfunction

    assign req  = {bus.hall_dn_req, bus.hall_up_req};
    assign cand = pending_q & ~assigned_q;

    // A call is served when its owner stands open and still at the call floor
    always_comb begin
        clr = '0;
        for (int e = 0; e < NE; e++) begin
            clr[e] = pending_q[e] & assigned_q[e]
                   & bus.lift_door_open[owner_q[e]]
                   & ~bus.lift_motion[owner_q[e]]
                   & (bus.lift_floor[int'(owner_q[e])*FW +: FW]
                      == floor_of(EW'(e)));
        end
    end

    // Round-robin search starting at the scan pointer
    always_comb begin
        int j;
        j        = 0;
        scan_hit = 1'b0;
        scan_sel = '0;
        for (int k = 0; k < NE; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NE) j = j - NE;
            if (!scan_hit && cand[j]) begin
                scan_hit = 1'b1;
                scan_sel = EW'(j);
            end
        end
    end

    always_comb begin
        cf   = floor_of(entry_q);
        lf   = bus.lift_floor[int'(eval_q)*FW +: FW];
        cost = (lf >= cf) ? CW'(lf - cf) : CW'(cf - lf);
        if (bus.lift_motion[eval_q]) cost = cost + CW'(N_FLOORS);
        better = bus.lift_avail[eval_q] && (!found_q || cost < best_q);
    end

    assign issue_fire = (state_q == ISSUE) && pending_q[entry_q];
    assign ptr_next   = (entry_q == EW'(NE - 1)) ? '0 : entry_q + 1'b1;

    always_comb begin
        issue_vec = '0;
        issue_vec[int'(winner_q)*N_FLOORS + int'(floor_of(entry_q))] = 1'b1;
    end

`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0] age_q [NE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < NE; e++) age_q[e] <= '0;
        end else begin
            for (int e = 0; e < NE; e++) begin
                if (issue_fire && entry_q == EW'(e))
                    age_q[e] <= '0;
                else if (assigned_q[e] && age_q[e] != 8'hFF)
                    age_q[e] <= age_q[e] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < NE; e++)
            aged[e] = assigned_q[e] && (age_q[e] == 8'(TIMEOUT_CYCLES));
    end
`else
    // No age counters: an assignment ends only by service or car loss
    assign aged = {NE{TIMEOUT_CYCLES < 1}};
`endif

    always_comb begin
        pending_d  = pending_q;
        assigned_d = assigned_q;
        owner_d    = owner_q;
        for (int e = 0; e < NE; e++) begin
            if (clr[e]) begin
                pending_d[e]  = 1'b0;
                assigned_d[e] = 1'b0;
                owner_d[e]    = '0;
            end else begin
                if (req[e] && !pending_q[e]) begin
                    pending_d[e]  = 1'b1;
                    assigned_d[e] = 1'b0;
                end
                if (issue_fire && entry_q == EW'(e)) begin
                    assigned_d[e] = 1'b1;
                    owner_d[e]    = winner_q;
                end else if (assigned_q[e]
                             && (!bus.lift_avail[owner_q[e]] || aged[e])) begin
                    assigned_d[e] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            assigned_q <= '0;
            for (int e = 0; e < NE; e++) owner_q[e] <= '0;
        end else begin
            pending_q  <= pending_d;
            assigned_q <= assigned_d;
            owner_q    <= owner_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            entry_q  <= '0;
            eval_q   <= '0;
            winner_q <= '0;
            found_q  <= 1'b0;
            best_q   <= '0;
            pulse_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            pulse_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        entry_q <= scan_sel;
                        eval_q  <= '0;
                        found_q <= 1'b0;
                        state_q <= EVAL;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                EVAL: begin
                    if (better) begin
                        found_q  <= 1'b1;
                        best_q   <= cost;
                        winner_q <= eval_q;
                    end
                    if (eval_q == LW'(N_LIFTS - 1)) begin
                        if (better || found_q) begin
                            state_q <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ptr_q   <= ptr_next;
                        end
                    end else begin
                        eval_q <= eval_q + 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_fire) pulse_q <= issue_vec;
                    ptr_q   <= ptr_next;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.assign_flr_rqst = pulse_q;
    assign bus.hall_up_pending = pending_q[N_FLOORS-1:0];
    assign bus.hall_dn_pending = pending_q[NE-1:N_FLOORS];
    assign bus.dispatch_busy   = busy_q;
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher: assignment, service, ties,
// motion cost, no-car, car loss, optional timeout and mid-dispatch reset.
module tb_hall_call_dispatcher;
    localparam int NF = 12;
    localparam int NL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [NL*NF-1:0] seen;

    hall_call_dispatcher_if #(.N_FLOORS(NF), .N_LIFTS(NL)) bus ();

    hall_call_dispatcher #(
        .N_FLOORS(NF), .N_LIFTS(NL), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_floors(input int a, input int b,
                              input int c, input int d);
        bus.lift_floor = {4'(d), 4'(c), 4'(b), 4'(a)};
    endtask

    // One-cycle call pulse; returns just after the sampling edge
    task automatic call(input bit up, input int f);
        if (up) bus.hall_up_req[f] = 1'b1;
        else    bus.hall_dn_req[f] = 1'b1;
        tick();
        bus.hall_up_req = '0;
        bus.hall_dn_req = '0;
    endtask

    task automatic watch(input int n);
        seen = '0;
        repeat (n) begin
            tick();
            seen |= bus.assign_flr_rqst;
        end
    endtask

    task automatic wait_pulse(input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bus.assign_flr_rqst != '0) break;
        end
    endtask

    initial begin
        bus.hall_up_req    = '0;
        bus.hall_dn_req    = '0;
        bus.lift_motion    = '0;
        bus.lift_door_open = '0;
        bus.lift_avail     = 4'hF;
        set_floors(0, 3, 6, 9);
        repeat (3) tick();
        chk("rst_pulse", bus.assign_flr_rqst, 0);
        chk("rst_up", bus.hall_up_pending, 0);
        chk("rst_dn", bus.hall_dn_pending, 0);
        chk("rst_busy", bus.dispatch_busy, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Nearest car: lift 2 at floor 6 for up call at 5
        call(1, 5);
        chk("c5_pend", bus.hall_up_pending, 64'h020);
        chk("c5_idle", bus.dispatch_busy, 0);
        tick();
        chk("c5_busy", bus.dispatch_busy, 1);
        repeat (5) tick();
        chk("c5_pre", bus.assign_flr_rqst, 0);
        tick();
        chk("c5_pulse", bus.assign_flr_rqst, 64'h1 << 29);
        tick();
        chk("c5_post", bus.assign_flr_rqst, 0);
        chk("c5_done", bus.dispatch_busy, 0);

        // Lift 2 services floor 5
        set_floors(0, 3, 5, 9);
        bus.lift_door_open = 4'b0100;
        tick();
        chk("c5_clr", bus.hall_up_pending, 0);
        watch(10);
        chk("c5_nopulse", seen, 0);
        bus.lift_door_open = '0;

        // Moving lift 2 pays N_FLOORS: lift 3 wins floor 7
        set_floors(0, 3, 6, 9);
        bus.lift_motion = 4'b0100;
        call(1, 7);
        repeat (6) tick();
        chk("mv_pre", bus.assign_flr_rqst, 0);
        tick();
        chk("mv_pulse", bus.assign_flr_rqst, 64'h1 << 43);
        bus.lift_motion = '0;
        set_floors(0, 3, 6, 7);
        bus.lift_door_open = 4'b1000;
        tick();
        chk("mv_clr", bus.hall_up_pending, 0);
        bus.lift_door_open = '0;
        tick();

        // Tie at cost 0 between lifts 0 and 2: lowest index wins
        set_floors(4, 0, 4, 11);
        call(0, 4);
        chk("t4_pend", bus.hall_dn_pending, 64'h010);
        repeat (6) tick();
        chk("t4_pre", bus.assign_flr_rqst, 0);
        tick();
        chk("t4_pulse", bus.assign_flr_rqst, 64'h1 << 4);
        bus.lift_door_open = 4'b0001;
        tick();
        chk("t4_clr", bus.hall_dn_pending, 0);
        bus.lift_door_open = '0;
        tick();

        // No car in service, then lift 3 returns at floor 2
        bus.lift_avail = '0;
        set_floors(0, 3, 6, 9);
        call(1, 2);
        watch(15);
        chk("na_nopulse", seen, 0);
        chk("na_pend", bus.hall_up_pending, 64'h004);
        set_floors(0, 3, 6, 2);
        bus.lift_avail = 4'b1000;
        wait_pulse(20);
        chk("na_pulse", bus.assign_flr_rqst, 64'h1 << 38);
        bus.lift_door_open = 4'b1000;
        tick();
        chk("na_clr", bus.hall_up_pending, 0);
        bus.lift_door_open = '0;
        bus.lift_avail = 4'hF;
        repeat (2) tick();

        // Owner lift 1 leaves service: call moves to lift 2
        set_floors(0, 3, 6, 9);
        call(1, 4);
        repeat (7) tick();
        chk("ra_pulse1", bus.assign_flr_rqst, 64'h1 << 16);
        bus.lift_avail = 4'b1101;
        repeat (7) tick();
        chk("ra_gap", bus.assign_flr_rqst, 0);
        tick();
        chk("ra_pulse2", bus.assign_flr_rqst, 64'h1 << 28);
        chk("ra_pend", bus.hall_up_pending, 64'h010);
`ifdef DISPATCH_TIMEOUT_EN
        wait_pulse(30);
        chk("to_pulse", bus.assign_flr_rqst, 64'h1 << 28);
`endif
        set_floors(0, 3, 4, 9);
        bus.lift_door_open = 4'b0100;
        tick();
        chk("ra_clr", bus.hall_up_pending, 0);
        bus.lift_door_open = '0;
        bus.lift_avail = 4'hF;
        set_floors(0, 3, 6, 9);
        repeat (2) tick();

        // Reset during EVAL kills the dispatch
        call(1, 8);
        repeat (3) tick();
        chk("rs_eval", bus.dispatch_busy, 1);
        reset = 1'b0;
        #1;
        chk("rs_busy", bus.dispatch_busy, 0);
        chk("rs_up", bus.hall_up_pending, 0);
        chk("rs_pulse", bus.assign_flr_rqst, 0);
        repeat (2) tick();
        reset = 1'b1;
        watch(10);
        chk("rs_nopulse", seen, 0);

        // First dispatch after reset keeps full latency
        call(1, 8);
        repeat (6) tick();
        chk("rs2_pre", bus.assign_flr_rqst, 0);
        tick();
        chk("rs2_pulse", bus.assign_flr_rqst, 64'h1 << 44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
